// File: rtl/div_unit_if.sv
// div_unit_if: request/response bundle between the core execute stage and
// the iterative divider.
//
// Handshake: the core (master) raises start with op/src1/src2 for one cycle
// while the divider is IDLE; busy is high combinationally in that cycle and
// stays high through the whole calculation, and the core holds its pipeline
// (en = !busy). done pulses for exactly one cycle with result valid in that
// cycle; busy is already low, so the core advances and writes back then.
// kill aborts whatever is in flight with no done pulse.
//
// Signals:
//   start  - request (master -> slave)
//   op     - 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   src1   - dividend
//   src2   - divisor
//   kill   - synchronous abort
//   busy   - stall request to the core
//   done   - one-cycle completion pulse
//   result - quotient or remainder, held until the next accepted start
interface div_unit_if #(
  parameter int XLEN = 64
);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic            kill;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, op, src1, src2, kill,
    input  busy, done, result
  );

  modport slave (
    input  start, op, src1, src2, kill,
    output busy, done, result
  );
endinterface

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for DIV/DIVU/REM/REMU,
// producing one quotient bit per cycle.
//
// Ports:
//   clk       - rising-edge clock
//   rstn      - asynchronous active-low reset
//   bus       - div_unit_if slave side (start/op/src1/src2/kill in,
//               busy/done/result out)
//   fsm_state - current FSM state (00 IDLE, 01 CALC, 10 DONE) for debug
module div_unit #(
  parameter int XLEN = 64
) (
  input  logic       clk,
  input  logic       rstn,
  div_unit_if.slave  bus,
  output logic [1:0] fsm_state
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int              CW      = $clog2(XLEN);
  localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]      state;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] dvd;       // dividend, refilled from the LSB with quotient bits
  logic [XLEN-1:0] dvs;       // divisor magnitude
  logic [XLEN-1:0] rem;       // partial remainder
  logic            want_rem;
  logic            neg_quo;
  logic            neg_rem;
  logic [XLEN-1:0] result_q;

  // Request decode
  logic            signed_op;
  logic            rem_op;
  logic            sign1;
  logic            sign2;
  logic [XLEN-1:0] abs1;
  logic [XLEN-1:0] abs2;
  logic            div_zero;
  logic            overflow;
  logic            accept;

  assign signed_op = !bus.op[0];
  assign rem_op    = bus.op[1];
  assign sign1     = signed_op && bus.src1[XLEN-1];
  assign sign2     = signed_op && bus.src2[XLEN-1];
  assign abs1      = sign1 ? -bus.src1 : bus.src1;
  assign abs2      = sign2 ? -bus.src2 : bus.src2;
  assign div_zero  = (bus.src2 == '0);
  assign overflow  = signed_op && (bus.src1 == MIN_NEG) && (bus.src2 == '1);
  assign accept    = (state == ST_IDLE) && bus.start && !bus.kill;

  // One restoring step. The partial remainder is always below the divisor,
  // so the shifted value is below twice the divisor: the top bit of the
  // XLEN+1 bit difference is set exactly when the trial subtraction borrows.
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   diff;
  logic            ge;
  logic [XLEN-1:0] rem_nx;
  logic [XLEN-1:0] quo_nx;
  logic [XLEN-1:0] res_quo;
  logic [XLEN-1:0] res_rem;

  assign rem_sh  = {rem, dvd[XLEN-1]};
  assign diff    = rem_sh - {1'b0, dvs};
  assign ge      = !diff[XLEN];
  assign rem_nx  = ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
  assign quo_nx  = {dvd[XLEN-2:0], ge};
  assign res_quo = neg_quo ? -quo_nx : quo_nx;
  assign res_rem = neg_rem ? -rem_nx : rem_nx;

  assign bus.busy   = accept || (state == ST_CALC);
  assign bus.done   = (state == ST_DONE) && !bus.kill;
  assign bus.result = result_q;
  assign fsm_state  = state;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= ST_IDLE;
      count    <= '0;
      dvd      <= '0;
      dvs      <= '0;
      rem      <= '0;
      want_rem <= 1'b0;
      neg_quo  <= 1'b0;
      neg_rem  <= 1'b0;
      result_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (div_zero) begin
              result_q <= rem_op ? bus.src1 : '1;
              state    <= ST_DONE;
            end else if (overflow) begin
              result_q <= rem_op ? '0 : bus.src1;
              state    <= ST_DONE;
            end else begin
              dvd      <= abs1;
              dvs      <= abs2;
              rem      <= '0;
              count    <= '0;
              want_rem <= rem_op;
              neg_quo  <= sign1 ^ sign2;
              neg_rem  <= sign1;
              state    <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (bus.kill) begin
            count <= '0;
            state <= ST_IDLE;
          end else begin
            dvd <= quo_nx;
            rem <= rem_nx;
            if (count == LAST) begin
              // Final step: sign-correct straight from the step outputs so
              // result is ready in the DONE cycle.
              result_q <= want_rem ? res_rem : res_quo;
              count    <= '0;
              state    <= ST_DONE;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
